// File: rtl/fifo_rd_stream_adapter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shared_pkg : widths and occupancy encoding shared by FIFO and read adapter
// Revision   : 1.0
// ---------------------------------------------------------------------------
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_skid_buf2 : 2-entry in-order buffer with occupancy FSM
// Revision         : 1.0
// ---------------------------------------------------------------------------
module stream_skid_buf2
    import shared_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output occ_state_e       occ_o
);

    occ_state_e       occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        if (flush_i) begin
            occ_d    = OCC_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            case (occ_q)
                OCC_EMPTY: if (push_i) occ_d = OCC_ONE;
                OCC_ONE: begin
                    if (push_i && !pop_i)      occ_d = OCC_TWO;
                    else if (pop_i && !push_i) occ_d = OCC_EMPTY;
                end
                OCC_TWO:   if (pop_i && !push_i) occ_d = OCC_ONE;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        valid_o = (occ_q != OCC_EMPTY);
        data_o  = mem_q[rd_ptr_q];
        occ_o   = occ_q;
    end

    // A push into a full buffer means the upstream credit accounting is broken
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(occ_q == OCC_TWO && push_i && !pop_i && !flush_i));

    a_legal_occ: assert property (@(posedge clk) disable iff (!rst_n)
        occ_q != occ_state_e'(2'd3));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter : pops a registered-read FIFO onto a valid/ready stream
// Revision               : 1.0
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter
    import shared_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow
);

    logic                 rd_pend_q, rd_pend_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic                 err_q, err_d;
    logic                 pop;
    logic                 push;
    logic [2:0]           credit_lvl;
    occ_state_e           occ;

    assign pop  = m_valid && m_ready;
    assign push = rd_pend_q && !flush;

    // Words held plus in flight, minus the one leaving now; m_ready feeds rd_en for 1 word/clk
    assign credit_lvl = {1'b0, occ} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && (credit_lvl < 3'd2);

    always_comb begin
        rd_pend_d  = fifo_rd_en;
        rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        err_d      = err_q | (fifo_rd_en & fifo_underflow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
        end
    end

    stream_skid_buf2 #(
        .WIDTH   (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fifo_data_out),
        .data_o  (m_data),
        .valid_o (m_valid),
        .occ_o   (occ)
    );

    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;

endmodule
`default_nettype wire
